pc_ctrl: RTL and testbench
==========================

# pc_ctrl

Program-counter and pipeline-control block for the five-signal in-order core. It owns the fetch address and consumes the execute stage's `jump_en2ctrl`, `jump_addr2ctrl` and `hold2ctrl`. It also consumes instruction-memory readiness. From these it drives the next PC plus flush/hold strobes for the IF/ID and ID/EX pipeline registers, and keeps sticky error and performance counters. It sits between execute and fetch, closing the redirect loop.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address loaded on reset
- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `jump_en2ctrl`  in  1  execute requests redirect this cycle
- `jump_addr2ctrl`  in  32  redirect target from execute
- `hold2ctrl`  in  1  execute requests stall (multi-cycle op)
- `imem_ready`  in  1  instruction memory can accept `ins_addr` this cycle
- `ins_addr`  out  32  current fetch address (registered PC)
- `flush_if_id`  out  1  IF/ID must load a bubble (NOP, addr 0) next edge
- `flush_id_ex`  out  1  ID/EX must load a bubble (oh=0, rd_wen=0) next edge
- `hold_if_id`  out  1  IF/ID must keep its contents next edge
- `misalign_err`  out  1  sticky: a redirect target had bit 1 set
- `cycle_cnt`  out  32  cycles since reset, wraps
- `bubble_cnt`  out  16  cycles with `flush_id_ex`=1, saturates at 16'hFFFF

## Operation
- FSM states: BOOT, RUN, STALL. Reset enters BOOT.
- BOOT: lasts exactly one cycle after `rst` falls. Asserts `flush_if_id` and `flush_id_ex`. PC does not advance. Goes to RUN unconditionally.
- RUN/STALL: next-PC priority, highest first:
  - `jump_en2ctrl`: PC <= {jump_addr2ctrl[31:1], 1'b0}. Assert `flush_if_id` and `flush_id_ex` this cycle. State -> RUN. If `jump_addr2ctrl[1]`=1, set `misalign_err`; the PC is still loaded with bit 1 preserved.
  - `hold2ctrl`: PC holds. Assert `hold_if_id` and `flush_id_ex`. State -> STALL.
  - `!imem_ready`: PC holds. Assert `hold_if_id` and `flush_id_ex`. State -> STALL.
  - Otherwise: PC <= PC + 4, wrapping mod 2^32. State -> RUN.
- A jump coincident with hold or `!imem_ready` wins. It redirects and flushes with no hold. `hold_if_id` and `flush_if_id` are never both 1.
- STALL returns to RUN on the first cycle where neither hold nor `!imem_ready` is present, or on a jump.
- `misalign_err` is cleared only by `rst`.
- `cycle_cnt` increments every cycle after reset, including BOOT.
- `bubble_cnt` increments on every cycle with `flush_id_ex`=1, including BOOT, and saturates at 16'hFFFF.

## Timing
- Reset values (async, immediate):
  - `ins_addr`=RESET_PC
  - `misalign_err`=0, `cycle_cnt`=0, `bubble_cnt`=0
  - state=BOOT
  - `flush_if_id`=1, `flush_id_ex`=1, `hold_if_id`=0 (BOOT decode)
- Flush/hold outputs are combinational from state and inputs, valid in the same cycle as the request. The pipeline registers act on the following edge.
- Redirect latency: jump asserted in cycle N gives `ins_addr`=target in cycle N+1. Exactly two bubbles are inserted: the IF/ID and ID/EX occupants of cycle N.
- Hold latency: the PC is frozen on the edge ending any cycle with hold or `!imem_ready`. Fetch resumes with PC+4 one edge after the release.
- `rst` asserted mid-operation (during STALL or in a jump cycle) discards everything. The block is in BOOT on the next observation and does not take the pending jump.
- `cycle_cnt` wraps from 32'hFFFF_FFFF to 0.

## Test plan
- Reset release, RESET_PC=0, `imem_ready`=1, no requests: BOOT cycle shows both flushes and `ins_addr`=0. Then `ins_addr` reads 0, 4, 8, 12 and `bubble_cnt`=1.
- Jump at `ins_addr`=8 with target 32'h100: flushes in that cycle, next `ins_addr`=32'h100, then 32'h104. `misalign_err`=0, `bubble_cnt` +1.
- `hold2ctrl` for 3 cycles at `ins_addr`=32'h20: `ins_addr` stays 32'h20 for those 3 cycles and the next, then 32'h24. `hold_if_id`=1 and `flush_id_ex`=1 in each hold cycle; `bubble_cnt` +3.
- Jump and hold together, target 32'h40: no `hold_if_id`, both flushes asserted, next `ins_addr`=32'h40.
- Jump to 32'h102: next `ins_addr`=32'h102, `misalign_err`=1 and it stays 1 after later aligned jumps until `rst`.
- Force `bubble_cnt` near saturation via a long `imem_ready`=0: it stops at 16'hFFFF. Asserting `rst` mid-stall clears all counters and `misalign_err` and restarts BOOT at RESET_PC.

Source files
------------

// File: rtl/pc_ctrl_if.sv
// pc_ctrl bus: execute redirect/stall requests, imem readiness,
// fetch address, pipeline strobes and status counters.
interface pc_ctrl_if;
  logic        jump_en2ctrl;
  logic [31:0] jump_addr2ctrl;
  logic        hold2ctrl;
  logic        imem_ready;
  logic [31:0] ins_addr;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        hold_if_id;
  logic        misalign_err;
  logic [31:0] cycle_cnt;
  logic [15:0] bubble_cnt;

  modport master (
    output jump_en2ctrl,
    output jump_addr2ctrl,
    output hold2ctrl,
    output imem_ready,
    input  ins_addr,
    input  flush_if_id,
    input  flush_id_ex,
    input  hold_if_id,
    input  misalign_err,
    input  cycle_cnt,
    input  bubble_cnt
  );

  modport slave (
    input  jump_en2ctrl,
    input  jump_addr2ctrl,
    input  hold2ctrl,
    input  imem_ready,
    output ins_addr,
    output flush_if_id,
    output flush_id_ex,
    output hold_if_id,
    output misalign_err,
    output cycle_cnt,
    output bubble_cnt
  );
endinterface

// File: rtl/pc_ctrl.sv
// Program counter and pipeline flush/hold control.
// Closes the execute->fetch redirect loop; keeps error/perf counters.
module pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic      clk,
  input  logic      rst,
  pc_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    STALL
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic        misalign;
  logic        misalign_set;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        hold_if_id;
  logic [31:0] cycle_cnt;
  logic [15:0] bubble_cnt;
  logic        stall_req;

  assign stall_req = bus.hold2ctrl | ~bus.imem_ready;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    hold_if_id   = 1'b0;
    misalign_set = 1'b0;
    if (state == BOOT) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      state_nxt   = RUN;
    end else if (bus.jump_en2ctrl) begin
      // jump outranks any stall request
      pc_nxt       = {bus.jump_addr2ctrl[31:1], 1'b0};
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      misalign_set = bus.jump_addr2ctrl[1];
      state_nxt    = RUN;
    end else if (stall_req) begin
      hold_if_id  = 1'b1;
      flush_id_ex = 1'b1;
      state_nxt   = STALL;
    end else begin
      pc_nxt    = pc + 32'd4;
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      misalign   <= 1'b0;
      cycle_cnt  <= 32'd0;
      bubble_cnt <= 16'd0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      misalign  <= misalign | misalign_set;
      cycle_cnt <= cycle_cnt + 32'd1;
      if (flush_id_ex && bubble_cnt != 16'hFFFF)
        bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

  assign bus.ins_addr     = pc;
  assign bus.flush_if_id  = flush_if_id;
  assign bus.flush_id_ex  = flush_id_ex;
  assign bus.hold_if_id   = hold_if_id;
  assign bus.misalign_err = misalign;
  assign bus.cycle_cnt    = cycle_cnt;
  assign bus.bubble_cnt   = bubble_cnt;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed-vector bench for pc_ctrl.
// Inputs change 1ns after posedge; outputs checked before the next edge.
module tb_pc_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pc_ctrl_if bus ();

  pc_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jump(input logic [31:0] a);
    bus.jump_en2ctrl   = 1'b1;
    bus.jump_addr2ctrl = a;
  endtask

  task automatic nojump();
    bus.jump_en2ctrl   = 1'b0;
    bus.jump_addr2ctrl = 32'd0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus.jump_en2ctrl   = 1'b0;
    bus.jump_addr2ctrl = 32'd0;
    bus.hold2ctrl      = 1'b0;
    bus.imem_ready     = 1'b1;
    tick();
    tick();
    chk("rst_addr", bus.ins_addr, 32'h0);
    chk("rst_fl_ifid", 32'(bus.flush_if_id), 32'd1);
    chk("rst_fl_idex", 32'(bus.flush_id_ex), 32'd1);
    chk("rst_hold", 32'(bus.hold_if_id), 32'd0);
    chk("rst_cyc", bus.cycle_cnt, 32'd0);
    chk("rst_bub", 32'(bus.bubble_cnt), 32'd0);
    chk("rst_mis", 32'(bus.misalign_err), 32'd0);

    // BOOT cycle
    rst = 1'b0;
    #1;
    chk("boot_fl_ifid", 32'(bus.flush_if_id), 32'd1);
    chk("boot_fl_idex", 32'(bus.flush_id_ex), 32'd1);
    chk("boot_addr", bus.ins_addr, 32'h0);
    tick();
    chk("run_addr0", bus.ins_addr, 32'h0);
    chk("run_bub1", 32'(bus.bubble_cnt), 32'd1);
    chk("run_fl_idex0", 32'(bus.flush_id_ex), 32'd0);
    tick();
    chk("run_addr4", bus.ins_addr, 32'h4);
    tick();
    chk("run_addr8", bus.ins_addr, 32'h8);
    chk("run_cyc3", bus.cycle_cnt, 32'd3);

    // aligned jump at 8
    jump(32'h100);
    #1;
    chk("j1_fl_ifid", 32'(bus.flush_if_id), 32'd1);
    chk("j1_fl_idex", 32'(bus.flush_id_ex), 32'd1);
    chk("j1_hold", 32'(bus.hold_if_id), 32'd0);
    tick();
    nojump();
    chk("j1_addr", bus.ins_addr, 32'h100);
    chk("j1_mis", 32'(bus.misalign_err), 32'd0);
    chk("j1_bub", 32'(bus.bubble_cnt), 32'd2);
    tick();
    chk("j1_addr_p4", bus.ins_addr, 32'h104);

    // 3-cycle hold at 0x20
    jump(32'h20);
    tick();
    nojump();
    chk("h_start", bus.ins_addr, 32'h20);
    bus.hold2ctrl = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("h_addr", bus.ins_addr, 32'h20);
      chk("h_hold", 32'(bus.hold_if_id), 32'd1);
      chk("h_fl_idex", 32'(bus.flush_id_ex), 32'd1);
      chk("h_fl_ifid", 32'(bus.flush_if_id), 32'd0);
      tick();
    end
    bus.hold2ctrl = 1'b0;
    chk("h_rel_addr", bus.ins_addr, 32'h20);
    chk("h_bub", 32'(bus.bubble_cnt), 32'd6);
    tick();
    chk("h_resume", bus.ins_addr, 32'h24);

    // jump coincident with hold
    bus.hold2ctrl = 1'b1;
    jump(32'h40);
    #1;
    chk("jh_hold", 32'(bus.hold_if_id), 32'd0);
    chk("jh_fl_ifid", 32'(bus.flush_if_id), 32'd1);
    chk("jh_fl_idex", 32'(bus.flush_id_ex), 32'd1);
    tick();
    bus.hold2ctrl = 1'b0;
    nojump();
    chk("jh_addr", bus.ins_addr, 32'h40);
    chk("jh_bub", 32'(bus.bubble_cnt), 32'd7);

    // misaligned target, then aligned
    jump(32'h102);
    tick();
    chk("mis_addr", bus.ins_addr, 32'h102);
    chk("mis_set", 32'(bus.misalign_err), 32'd1);
    jump(32'h200);
    tick();
    nojump();
    chk("mis_addr2", bus.ins_addr, 32'h200);
    chk("mis_sticky", 32'(bus.misalign_err), 32'd1);
    chk("mis_bub", 32'(bus.bubble_cnt), 32'd9);

    // long imem stall saturates bubble_cnt
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 65600; i++) tick();
    chk("sat_bub", 32'(bus.bubble_cnt), 32'h0000_FFFF);
    chk("sat_addr", bus.ins_addr, 32'h200);
    chk("sat_hold", 32'(bus.hold_if_id), 32'd1);

    // async reset mid-stall with a pending jump
    jump(32'h300);
    rst = 1'b1;
    #1;
    chk("mr_addr", bus.ins_addr, 32'h0);
    chk("mr_mis", 32'(bus.misalign_err), 32'd0);
    chk("mr_cyc", bus.cycle_cnt, 32'd0);
    chk("mr_bub", 32'(bus.bubble_cnt), 32'd0);
    chk("mr_hold", 32'(bus.hold_if_id), 32'd0);
    chk("mr_fl_ifid", 32'(bus.flush_if_id), 32'd1);
    tick();
    chk("mr_addr_edge", bus.ins_addr, 32'h0);
    nojump();
    bus.imem_ready = 1'b1;
    rst = 1'b0;
    #1;
    chk("rb_fl_idex", 32'(bus.flush_id_ex), 32'd1);
    tick();
    chk("rb_addr0", bus.ins_addr, 32'h0);
    chk("rb_bub", 32'(bus.bubble_cnt), 32'd1);
    tick();
    chk("rb_addr4", bus.ins_addr, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
